// File: rtl/multicycle_ctrl.sv
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : RV32I multi-cycle sequencer (FETCH/DECODE/EXEC/MEM/WB) with
//                memory handshakes, retire counter and sticky trap.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [3:0]       alu_op,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap
);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_fetch  = 3'd1;
    localparam logic [2:0] c_decode = 3'd2;
    localparam logic [2:0] c_exec   = 3'd3;
    localparam logic [2:0] c_mem    = 3'd4;
    localparam logic [2:0] c_wb     = 3'd5;
    localparam logic [2:0] c_trap   = 3'd6;

    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_reg    = 7'b0110011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    localparam logic [3:0] c_alu_add = 4'b0000;
    localparam logic [3:0] c_alu_sub = 4'b0001;

    localparam int             c_tw    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_tw-1:0] c_tlast = c_tw'(MEM_TIMEOUT - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [6:0]       r_opcode;
    logic [2:0]       r_funct3;
    logic [c_tw-1:0]  r_tcnt;
    logic             w_tcnt_inc;
    logic [CNT_W-1:0] r_instret;
    logic             w_is_store;

    assign w_is_store = (r_opcode == c_op_store);
    assign instret    = r_instret;

    always_comb begin
        w_next     = r_state;
        w_tcnt_inc = 1'b0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = c_alu_add;
        retire     = 1'b0;
        trap       = 1'b0;
        case (r_state)
            c_idle: w_next = c_fetch;
            c_fetch: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    w_next   = c_decode;
                end else if (r_tcnt == c_tlast) begin
                    w_next = c_trap;
                end else begin
                    w_tcnt_inc = 1'b1;
                end
            end
            c_decode: begin
                case (opcode)
                    c_op_imm, c_op_reg, c_op_load, c_op_store, c_op_branch: w_next = c_exec;
                    default: w_next = c_trap;
                endcase
            end
            c_exec: begin
                case (r_opcode)
                    c_op_imm: begin
                        alu_src = 1'b1;
                        w_next  = c_wb;
                    end
                    c_op_reg: w_next = c_wb;
                    c_op_load, c_op_store: begin
                        alu_src = 1'b1;
                        w_next  = c_mem;
                    end
                    c_op_branch: begin
                        alu_op = c_alu_sub;
                        if (r_funct3 == 3'b000 || r_funct3 == 3'b001) begin
                            // funct3[0] selects BNE: taken when the compare is non-zero
                            pc_write = 1'b1;
                            pc_src   = r_funct3[0] ? !zero : zero;
                            retire   = 1'b1;
                            w_next   = c_fetch;
                        end else begin
                            w_next = c_trap;
                        end
                    end
                    default: w_next = c_trap;
                endcase
            end
            c_mem: begin
                dmem_req = 1'b1;
                dmem_we  = w_is_store;
                alu_src  = 1'b1;
                if (dmem_ready) begin
                    if (w_is_store) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        w_next   = c_fetch;
                    end else begin
                        w_next = c_wb;
                    end
                end else if (r_tcnt == c_tlast) begin
                    w_next = c_trap;
                end else begin
                    w_tcnt_inc = 1'b1;
                end
            end
            c_wb: begin
                reg_write  = 1'b1;
                mem_to_reg = (r_opcode == c_op_load);
                pc_write   = 1'b1;
                retire     = 1'b1;
                w_next     = c_fetch;
            end
            c_trap: trap = 1'b1;
            default: w_next = c_idle;
        endcase
    end

    // Timeout count only advances while waiting; any transition or ready clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_idle;
            r_opcode  <= 7'd0;
            r_funct3  <= 3'd0;
            r_tcnt    <= '0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == c_decode) begin
                r_opcode <= opcode;
                r_funct3 <= funct3;
            end
            r_tcnt <= w_tcnt_inc ? r_tcnt + c_tw'(1) : '0;
            if (retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Self-checking bench for multicycle_ctrl: per-instruction
//                expected strobe traces plus randomized instruction stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    localparam int TO = 16;
    localparam int CW = 4;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Strobe vector: {imem_req,dmem_req,dmem_we,ir_write,pc_write,pc_src,
    //                 reg_write,mem_to_reg,alu_src,alu_op[3:0],retire,trap}
    localparam logic [14:0] V_IREQ = 15'h4000;
    localparam logic [14:0] V_DREQ = 15'h2000;
    localparam logic [14:0] V_DWE  = 15'h1000;
    localparam logic [14:0] V_IRW  = 15'h0800;
    localparam logic [14:0] V_PCW  = 15'h0400;
    localparam logic [14:0] V_PCS  = 15'h0200;
    localparam logic [14:0] V_RW   = 15'h0100;
    localparam logic [14:0] V_M2R  = 15'h0080;
    localparam logic [14:0] V_ASRC = 15'h0040;
    localparam logic [14:0] V_SUB  = 15'h0004;
    localparam logic [14:0] V_RET  = 15'h0002;
    localparam logic [14:0] V_TRP  = 15'h0001;

    logic          clk;
    logic          reset;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          zero;
    logic          imem_ready;
    logic          dmem_ready;
    logic          imem_req;
    logic          dmem_req;
    logic          dmem_we;
    logic          ir_write;
    logic          pc_write;
    logic          pc_src;
    logic          reg_write;
    logic          mem_to_reg;
    logic          alu_src;
    logic [3:0]    alu_op;
    logic          retire;
    logic [CW-1:0] instret;
    logic          trap;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct3     (funct3),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .retire     (retire),
        .instret    (instret),
        .trap       (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [14:0] w_act;
    assign w_act = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
                    reg_write, mem_to_reg, alu_src, alu_op, retire, trap};

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [CW-1:0] m_instret;
    int            n_ireq, n_dreq, n_dwe, n_m2r, n_rw, n_pcs, n_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic r1();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] ro();
        return 7'($urandom);
    endfunction

    function automatic logic [2:0] rf();
        return 3'($urandom);
    endfunction

    function automatic logic legal(input logic [6:0] op);
        return (op == OP_IMM) || (op == OP_REG) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    task automatic clr();
        n_ireq = 0; n_dreq = 0; n_dwe = 0; n_m2r = 0; n_rw = 0; n_pcs = 0; n_cyc = 0;
    endtask

    // One clock cycle: entered and left at posedge+1; outputs compared at negedge
    task automatic cyc(input logic [14:0] e, input logic ir, input logic dr,
                       input logic [6:0] op, input logic [2:0] f3, input logic z);
        imem_ready = ir;
        dmem_ready = dr;
        opcode     = op;
        funct3     = f3;
        zero       = z;
        @(negedge clk);
        check("strobes", 32'(w_act), 32'(e));
        check("instret", 32'(instret), 32'(m_instret));
        n_cyc++;
        if (imem_req)   n_ireq++;
        if (dmem_req)   n_dreq++;
        if (dmem_we)    n_dwe++;
        if (mem_to_reg) n_m2r++;
        if (reg_write)  n_rw++;
        if (pc_src)     n_pcs++;
        if ((e & V_RET) != 15'h0) m_instret = m_instret + CW'(1);
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        reset     = 1'b0;
        m_instret = '0;
        cyc(15'h0, r1(), r1(), ro(), rf(), r1());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset_strobes", 32'(w_act), 32'h0);
        check("reset_instret", 32'(instret), 32'h0);
        @(posedge clk);
        #1;
        release_reset();
    endtask

    task automatic trap_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(V_TRP, r1(), r1(), ro(), rf(), r1());
    endtask

    // Expected trace of one instruction from its class and memory wait counts
    task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                            input int wi, input int wd, input int abort_mem,
                            output logic trapped);
        logic        is_ld;
        logic        is_st;
        logic        taken;
        logic [14:0] mbase;
        trapped = 1'b0;
        is_ld   = (op == OP_LOAD);
        is_st   = (op == OP_STORE);
        for (int k = 0; k < TO; k++) begin
            if (k == wi) begin
                cyc(V_IREQ | V_IRW, 1'b1, r1(), ro(), rf(), r1());
                break;
            end
            cyc(V_IREQ, 1'b0, r1(), ro(), rf(), r1());
            if (k == TO - 1) begin
                trapped = 1'b1;
                return;
            end
        end
        cyc(15'h0, r1(), r1(), op, f3, r1());
        if (!legal(op)) begin
            trapped = 1'b1;
            return;
        end
        if (op == OP_BRANCH) begin
            if (f3 == 3'b000 || f3 == 3'b001) begin
                taken = (f3 == 3'b000) ? z : !z;
                cyc(V_SUB | V_PCW | (taken ? V_PCS : 15'h0) | V_RET, r1(), r1(), ro(), rf(), z);
            end else begin
                cyc(V_SUB, r1(), r1(), ro(), rf(), z);
                trapped = 1'b1;
            end
            return;
        end
        cyc((op == OP_REG) ? 15'h0 : V_ASRC, r1(), r1(), ro(), rf(), r1());
        if (is_ld || is_st) begin
            mbase = V_DREQ | V_ASRC | (is_st ? V_DWE : 15'h0);
            for (int k = 0; k < TO; k++) begin
                if (k == abort_mem) return;
                if (k == wd) begin
                    cyc(mbase | (is_st ? (V_PCW | V_RET) : 15'h0), r1(), 1'b1, ro(), rf(), r1());
                    if (is_st) return;
                    break;
                end
                cyc(mbase, r1(), 1'b0, ro(), rf(), r1());
                if (k == TO - 1) begin
                    trapped = 1'b1;
                    return;
                end
            end
        end
        cyc(V_RW | (is_ld ? V_M2R : 15'h0) | V_PCW | V_RET, r1(), r1(), ro(), rf(), r1());
    endtask

    function automatic int pick_wait();
        if ($urandom_range(0, 19) == 0) return int'($urandom_range(14, 17));
        return int'($urandom_range(0, 2));
    endfunction

    initial begin
        logic       tr;
        logic [6:0] op;
        logic [2:0] f3;
        logic       z;
        int         kind;

        reset      = 1'b1;
        opcode     = 7'd0;
        funct3     = 3'd0;
        zero       = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        m_instret  = '0;
        clr();
        #2;
        check("por_strobes", 32'(w_act), 32'h0);
        check("por_instret", 32'(instret), 32'h0);
        @(posedge clk);
        #1;
        release_reset();

        // ADDI, fetch ready in first cycle
        clr();
        do_instr(OP_IMM, 3'b000, 1'b0, 0, 0, -1, tr);
        check("addi_instret", 32'(instret), 32'd1);
        check("addi_regwrite_cycles", 32'(n_rw), 32'd1);
        check("addi_cycles", 32'(n_cyc), 32'd4);

        // LW with dmem_ready three cycles late
        clr();
        do_instr(OP_LOAD, 3'b010, 1'b0, 0, 3, -1, tr);
        check("lw_dmem_req_cycles", 32'(n_dreq), 32'd4);
        check("lw_dmem_we_cycles", 32'(n_dwe), 32'd0);
        check("lw_mem_to_reg_cycles", 32'(n_m2r), 32'd1);
        check("lw_instret", 32'(instret), 32'd2);

        // BEQ then BNE, both with zero=1
        clr();
        do_instr(OP_BRANCH, 3'b000, 1'b1, 0, 0, -1, tr);
        check("beq_pc_src_cycles", 32'(n_pcs), 32'd1);
        do_instr(OP_BRANCH, 3'b001, 1'b1, 0, 0, -1, tr);
        check("bne_pc_src_cycles", 32'(n_pcs), 32'd1);
        check("branch_regwrite_cycles", 32'(n_rw), 32'd0);
        check("branch_instret", 32'(instret), 32'd4);

        // Illegal opcode
        do_instr(7'b1111111, 3'b000, 1'b0, 0, 0, -1, tr);
        clr();
        trap_cycles(5);
        check("illegal_imem_req_cycles", 32'(n_ireq), 32'd0);
        check("illegal_trap", 32'(trap), 32'd1);
        check("illegal_instret", 32'(instret), 32'd4);
        do_reset();

        // Fetch timeout, then ready on the last permitted cycle
        clr();
        do_instr(OP_IMM, 3'b000, 1'b0, TO + 3, 0, -1, tr);
        check("timeout_imem_req_cycles", 32'(n_ireq), 32'd16);
        check("timeout_trap", 32'(trap), 32'd1);
        trap_cycles(2);
        do_reset();
        clr();
        do_instr(OP_IMM, 3'b000, 1'b0, TO - 1, 0, -1, tr);
        check("late_ready_imem_req_cycles", 32'(n_ireq), 32'd16);
        check("late_ready_instret", 32'(instret), 32'd1);

        // Reset asserted in the middle of a store's MEM phase
        do_instr(OP_STORE, 3'b010, 1'b0, 0, 100, 2, tr);
        check("sw_mid_dmem_req", 32'(dmem_req), 32'd1);
        check("sw_mid_dmem_we", 32'(dmem_we), 32'd1);
        check("sw_mid_instret", 32'(instret), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("sw_rst_dmem_req", 32'(dmem_req), 32'd0);
        check("sw_rst_dmem_we", 32'(dmem_we), 32'd0);
        check("sw_rst_instret", 32'(instret), 32'd0);
        check("sw_rst_strobes", 32'(w_act), 32'h0);
        @(posedge clk);
        #1;
        release_reset();

        // instret wraps after 2^CW retires
        for (int i = 0; i < 17; i++) do_instr(OP_REG, rf(), 1'b0, 0, 0, -1, tr);
        check("wrap_instret", 32'(instret), 32'd1);

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 15));
            f3   = rf();
            z    = r1();
            case (kind)
                0, 1, 2:  op = OP_IMM;
                3, 4:     op = OP_REG;
                5, 6:     op = OP_LOAD;
                7, 8:     op = OP_STORE;
                9, 10, 11: begin
                    op = OP_BRANCH;
                    f3 = {2'b00, r1()};
                end
                12: begin
                    op = OP_BRANCH;
                    f3 = 3'($urandom_range(2, 7));
                end
                13: begin
                    op = ro();
                    while (legal(op)) op = ro();
                end
                default: op = OP_IMM;
            endcase
            do_instr(op, f3, z, pick_wait(), pick_wait(), -1, tr);
            if (tr) begin
                trap_cycles(2);
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
